// File: rtl/instr_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// instr_prefetch_buffer
//
// Sequential instruction prefetcher that sits between the on-chip instruction
// RAM (Avalon slave, 32-bit, one-cycle read latency) and the processor fetch
// stage. It streams word reads from a fetch pointer into a small FIFO and
// presents the words on a valid/ready interface. A redirect (branch, jump or
// exception) throws away everything queued or in flight and restarts fetch
// at a new word address.
//
// Ports
//   clk             clock, single domain
//   reset_n         synchronous active-low reset
//   mem_address     RAM word address (the current fetch pointer)
//   mem_chipselect  read request strobe, at most one request per cycle
//   mem_clken       RAM clock enable, tied high
//   mem_write       tied low, this block only reads
//   mem_byteenable  tied to all lanes
//   mem_readdata    RAM data, valid the cycle after the request
//   redirect_valid  restart fetch at redirect_addr
//   redirect_addr   new word address
//   instr_valid     instr_data / instr_addr hold a valid instruction
//   instr_ready     consumer accepts the instruction this cycle
//   instr_data      instruction word at the FIFO head
//   instr_addr      word address of instr_data
//   addr_err        sticky flag, set by a redirect beyond the RAM
// ---------------------------------------------------------------------------
module instr_prefetch_buffer #(
   parameter int ADDR_W    = 15,
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 4,
   parameter int MEM_WORDS = 24576,
   parameter int RESET_PC  = 0
) (
   input  logic              clk,
   input  logic              reset_n,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_chipselect,
   output logic              mem_clken,
   output logic              mem_write,
   output logic [3:0]        mem_byteenable,
   input  logic [DATA_W-1:0] mem_readdata,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic              instr_valid,
   input  logic              instr_ready,
   output logic [DATA_W-1:0] instr_data,
   output logic [ADDR_W-1:0] instr_addr,
   output logic              addr_err
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(MEM_WORDS - 1);
   localparam logic [ADDR_W:0]   MEM_LIMIT  = (ADDR_W + 1)'(MEM_WORDS);
   localparam logic [ADDR_W-1:0] RESET_ADDR = ADDR_W'(RESET_PC);
   localparam logic [CNT_W:0]    DEPTH_C    = (CNT_W + 1)'(DEPTH);

   typedef enum logic {
      RUN,
      FLUSH
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   fetchPtr_q, fetchPtr_d;
   logic                inflight_q, inflight_d;
   logic [ADDR_W-1:0]   inflightAddr_q, inflightAddr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [PTR_W-1:0]    wrPtr_q, wrPtr_d;
   logic [PTR_W-1:0]    rdPtr_q, rdPtr_d;
   logic                addrErr_q, addrErr_d;

   logic [DATA_W-1:0]   fifoData_q [DEPTH];
   logic [ADDR_W-1:0]   fifoAddr_q [DEPTH];

   logic                headValid;
   logic                pop;
   logic                push;
   logic                issue;
   logic                redirectInRange;
   logic [CNT_W:0]      credit;

   // The head is only offered while running with something queued. In FLUSH
   // the count is already zero, the explicit state term just makes the
   // "nothing valid during flush" rule obvious.
   assign headValid = (state_q == RUN) && (count_q != '0);
   assign instr_valid = reset_n & headValid;
   assign pop = instr_valid & instr_ready;

   // Credit check: words that will still be queued after this cycle's pop plus
   // the word on its way back from the RAM must leave room for one more. This
   // is what keeps the FIFO from overflowing without any back-pressure on the
   // RAM side, and it still allows one issue per cycle at DEPTH = 2.
   assign credit = (CNT_W + 1)'(count_q) - (CNT_W + 1)'(pop) + (CNT_W + 1)'(inflight_q);
   assign issue = reset_n & ~redirect_valid & (credit < DEPTH_C);

   // A response that lands in the same cycle as a redirect belongs to the old
   // stream and is dropped. Because a redirect blocks issuing, nothing can be
   // in flight during FLUSH; the state term covers that case defensively.
   assign push = reset_n & inflight_q & ~redirect_valid & (state_q == RUN);

   assign redirectInRange = ({1'b0, redirect_addr} < MEM_LIMIT);

   // Next-state logic: FSM, fetch pointer, in-flight tracking and FIFO
   // bookkeeping. A redirect clears the queue outright (a pop in the same
   // cycle still completes, the consumer already owns that word).
   always_comb begin
      state_d        = state_q;
      fetchPtr_d     = fetchPtr_q;
      inflight_d     = issue;
      inflightAddr_d = fetchPtr_q;
      count_d        = count_q;
      wrPtr_d        = wrPtr_q;
      rdPtr_d        = rdPtr_q;
      addrErr_d      = addrErr_q;

      case (state_q)
         RUN: begin
            if (redirect_valid) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            // A second redirect while flushing simply restarts the flush with
            // the newer target; the older one is never fetched.
            if (redirect_valid) begin
               state_d = FLUSH;
            end else begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = RUN;
         end
      endcase

      if (redirect_valid) begin
         if (redirectInRange) begin
            fetchPtr_d = redirect_addr;
         end else begin
            fetchPtr_d = '0;
            addrErr_d  = 1'b1;
         end
         count_d = '0;
         wrPtr_d = '0;
         rdPtr_d = '0;
      end else begin
         if (issue) begin
            if (fetchPtr_q == LAST_ADDR) begin
               fetchPtr_d = '0;
            end else begin
               fetchPtr_d = fetchPtr_q + ADDR_W'(1);
            end
         end
         if (push) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
         end
         if (pop) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Control state registers with synchronous reset. Clearing the count and
   // the in-flight flag is enough to guarantee no stale word resurfaces.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q        <= RUN;
         fetchPtr_q     <= RESET_ADDR;
         inflight_q     <= 1'b0;
         inflightAddr_q <= '0;
         count_q        <= '0;
         wrPtr_q        <= '0;
         rdPtr_q        <= '0;
         addrErr_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         fetchPtr_q     <= fetchPtr_d;
         inflight_q     <= inflight_d;
         inflightAddr_q <= inflightAddr_d;
         count_q        <= count_d;
         wrPtr_q        <= wrPtr_d;
         rdPtr_q        <= rdPtr_d;
         addrErr_q      <= addrErr_d;
      end
   end

   // FIFO storage. No reset needed: an entry is only ever read after it has
   // been written, since the count gates instr_valid.
   always_ff @(posedge clk) begin
      if (push) begin
         fifoData_q[wrPtr_q] <= mem_readdata;
         fifoAddr_q[wrPtr_q] <= inflightAddr_q;
      end
   end

   // Head of the FIFO drives the fetch-stage outputs; forced to zero while
   // reset is asserted.
   always_comb begin
      instr_data = '0;
      instr_addr = '0;
      if (reset_n) begin
         instr_data = fifoData_q[rdPtr_q];
         instr_addr = fifoAddr_q[rdPtr_q];
      end
   end

   assign mem_address    = fetchPtr_q;
   assign mem_chipselect = issue;
   assign mem_clken      = 1'b1;
   assign mem_write      = 1'b0;
   assign mem_byteenable = 4'hF;
   assign addr_err       = addrErr_q;

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// ---------------------------------------------------------------------------
// tb_instr_prefetch_buffer
//
// Directed bench for instr_prefetch_buffer. A behavioural RAM returns
// word*3 one cycle after each chipselect. Streaming and back-pressure are
// driven from a vector table; redirects, address wrap, out-of-range targets
// and mid-stream reset use hand-written sequences built from the same record.
// ---------------------------------------------------------------------------
module tb_instr_prefetch_buffer;

   localparam int ADDR_W = 15;
   localparam int DATA_W = 32;

   logic              clk;
   logic              reset_n;
   logic [ADDR_W-1:0] mem_address;
   logic              mem_chipselect;
   logic              mem_clken;
   logic              mem_write;
   logic [3:0]        mem_byteenable;
   logic [DATA_W-1:0] mem_readdata = '0;
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_addr;
   logic              instr_valid;
   logic              instr_ready;
   logic [DATA_W-1:0] instr_data;
   logic [ADDR_W-1:0] instr_addr;
   logic              addr_err;

   int nCompared = 0;
   int nMismatch = 0;
   int cycleIdx  = 0;

   typedef struct {
      int                tid;
      logic              rstN;
      logic              ready;
      logic              redir;
      logic [ADDR_W-1:0] raddr;
      logic              chkOut;
      logic              expValid;
      logic [ADDR_W-1:0] expAddr;
      logic              chkCs;
      logic              expCs;
      logic [ADDR_W-1:0] expMemAddr;
   } vec_t;

   vec_t vecs[$];

   instr_prefetch_buffer #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .DEPTH(4),
      .MEM_WORDS(24576),
      .RESET_PC(0)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .mem_address(mem_address),
      .mem_chipselect(mem_chipselect),
      .mem_clken(mem_clken),
      .mem_write(mem_write),
      .mem_byteenable(mem_byteenable),
      .mem_readdata(mem_readdata),
      .redirect_valid(redirect_valid),
      .redirect_addr(redirect_addr),
      .instr_valid(instr_valid),
      .instr_ready(instr_ready),
      .instr_data(instr_data),
      .instr_addr(instr_addr),
      .addr_err(addr_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction RAM model: RAM[w] = w*3, one-cycle read latency
   always @(posedge clk) begin
      if (mem_chipselect) begin
         mem_readdata <= 32'(mem_address) * 32'd3;
      end
   end

   function automatic vec_t mkVec(input int tid, input logic rstN, input logic ready,
                                  input logic redir, input logic [ADDR_W-1:0] raddr,
                                  input logic chkOut, input logic expValid,
                                  input logic [ADDR_W-1:0] expAddr, input logic chkCs,
                                  input logic expCs, input logic [ADDR_W-1:0] expMemAddr);
      vec_t v;
      v.tid = tid; v.rstN = rstN; v.ready = ready; v.redir = redir; v.raddr = raddr;
      v.chkOut = chkOut; v.expValid = expValid; v.expAddr = expAddr;
      v.chkCs = chkCs; v.expCs = expCs; v.expMemAddr = expMemAddr;
      return v;
   endfunction

   task automatic cmp(input string what, input int tid, input logic [31:0] got,
                      input logic [31:0] want);
      nCompared++;
      if (got !== want) begin
         nMismatch++;
         $display("[TB] FAIL t%0d cyc%0d %s: got %0h want %0h", tid, cycleIdx, what, got, want);
      end
   endtask

   task automatic checkOutput(input vec_t v);
      if (v.chkOut) begin
         cmp("instr_valid", v.tid, 32'(instr_valid), 32'(v.expValid));
         if (v.expValid) begin
            cmp("instr_addr", v.tid, 32'(instr_addr), 32'(v.expAddr));
            cmp("instr_data", v.tid, instr_data, 32'(v.expAddr) * 32'd3);
         end
      end
      if (v.chkCs) begin
         cmp("mem_chipselect", v.tid, 32'(mem_chipselect), 32'(v.expCs));
         if (v.expCs) begin
            cmp("mem_address", v.tid, 32'(mem_address), 32'(v.expMemAddr));
         end
      end
   endtask

   // One clock cycle: drive inputs just after the edge, check mid-cycle
   task automatic applyStimulus(input vec_t v);
      @(posedge clk);
      #1;
      cycleIdx++;
      reset_n        = v.rstN;
      instr_ready    = v.ready;
      redirect_valid = v.redir;
      redirect_addr  = v.raddr;
      #3;
      checkOutput(v);
   endtask

   initial begin
      reset_n        = 1'b0;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_addr  = '0;

      // Table: reset-release streaming, then back-pressure and drain
      vecs.push_back(mkVec(1, 1, 1, 0, 0, 1, 0, 0, 1, 1, 0));
      vecs.push_back(mkVec(1, 1, 1, 0, 0, 1, 0, 0, 1, 1, 1));
      for (int k = 2; k <= 5; k++)
         vecs.push_back(mkVec(1, 1, 1, 0, 0, 1, 1, ADDR_W'(k - 2), 1, 1, ADDR_W'(k)));
      vecs.push_back(mkVec(2, 1, 0, 0, 0, 1, 1, 4, 1, 1, 6));
      vecs.push_back(mkVec(2, 1, 0, 0, 0, 1, 1, 4, 1, 1, 7));
      for (int k = 8; k <= 25; k++)
         vecs.push_back(mkVec(2, 1, 0, 0, 0, 1, 1, 4, 1, 0, 0));
      for (int k = 26; k <= 31; k++)
         vecs.push_back(mkVec(2, 1, 1, 0, 0, 1, 1, ADDR_W'(k - 22), 1, 1, ADDR_W'(k - 18)));

      // Reset state
      applyStimulus(mkVec(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
      applyStimulus(mkVec(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
      cmp("rst instr_data", 0, instr_data, 32'd0);
      cmp("rst instr_addr", 0, 32'(instr_addr), 32'd0);
      cmp("rst addr_err", 0, 32'(addr_err), 32'd0);
      cmp("mem_clken", 0, 32'(mem_clken), 32'd1);
      cmp("mem_write", 0, 32'(mem_write), 32'd0);
      cmp("mem_byteenable", 0, 32'(mem_byteenable), 32'hF);

      foreach (vecs[i]) applyStimulus(vecs[i]);

      // Redirect to 0x0E, stream to 0x10, then redirect to 0x100 with a pop
      applyStimulus(mkVec(3, 1, 1, 1, 15'h0E, 1, 1, 10, 1, 0, 0));
      applyStimulus(mkVec(3, 1, 1, 0, 0, 1, 0, 0, 1, 1, 15'h0E));
      applyStimulus(mkVec(3, 1, 1, 0, 0, 1, 0, 0, 1, 1, 15'h0F));
      applyStimulus(mkVec(3, 1, 1, 0, 0, 1, 1, 15'h0E, 1, 1, 15'h10));
      applyStimulus(mkVec(3, 1, 1, 0, 0, 1, 1, 15'h0F, 1, 1, 15'h11));
      applyStimulus(mkVec(3, 1, 1, 1, 15'h100, 1, 1, 15'h10, 1, 0, 0));
      applyStimulus(mkVec(3, 1, 1, 0, 0, 1, 0, 0, 1, 1, 15'h100));
      applyStimulus(mkVec(3, 1, 1, 0, 0, 1, 0, 0, 1, 1, 15'h101));
      applyStimulus(mkVec(3, 1, 1, 0, 0, 1, 1, 15'h100, 1, 1, 15'h102));
      applyStimulus(mkVec(3, 1, 1, 0, 0, 1, 1, 15'h101, 1, 1, 15'h103));
      applyStimulus(mkVec(3, 1, 1, 0, 0, 1, 1, 15'h102, 1, 1, 15'h104));

      // Fetch pointer wraps from the last RAM word to 0
      applyStimulus(mkVec(4, 1, 1, 1, 15'd24574, 0, 0, 0, 1, 0, 0));
      applyStimulus(mkVec(4, 1, 1, 0, 0, 1, 0, 0, 1, 1, 15'd24574));
      applyStimulus(mkVec(4, 1, 1, 0, 0, 1, 0, 0, 1, 1, 15'd24575));
      applyStimulus(mkVec(4, 1, 1, 0, 0, 1, 1, 15'd24574, 1, 1, 0));
      applyStimulus(mkVec(4, 1, 1, 0, 0, 1, 1, 15'd24575, 1, 1, 1));
      applyStimulus(mkVec(4, 1, 1, 0, 0, 1, 1, 0, 1, 1, 2));
      applyStimulus(mkVec(4, 1, 1, 0, 0, 1, 1, 1, 1, 1, 3));
      cmp("addr_err in range", 4, 32'(addr_err), 32'd0);

      // Out-of-range redirect, then back-to-back redirects
      applyStimulus(mkVec(5, 1, 1, 1, 15'd24600, 0, 0, 0, 1, 0, 0));
      applyStimulus(mkVec(5, 1, 1, 0, 0, 1, 0, 0, 1, 1, 0));
      cmp("addr_err set", 5, 32'(addr_err), 32'd1);
      applyStimulus(mkVec(5, 1, 1, 0, 0, 1, 0, 0, 1, 1, 1));
      applyStimulus(mkVec(5, 1, 1, 0, 0, 1, 1, 0, 1, 1, 2));
      applyStimulus(mkVec(5, 1, 1, 0, 0, 1, 1, 1, 1, 1, 3));
      applyStimulus(mkVec(5, 1, 1, 1, 15'h40, 0, 0, 0, 1, 0, 0));
      applyStimulus(mkVec(5, 1, 1, 1, 15'h80, 1, 0, 0, 1, 0, 0));
      applyStimulus(mkVec(5, 1, 1, 0, 0, 1, 0, 0, 1, 1, 15'h80));
      applyStimulus(mkVec(5, 1, 1, 0, 0, 1, 0, 0, 1, 1, 15'h81));
      applyStimulus(mkVec(5, 1, 1, 0, 0, 1, 1, 15'h80, 1, 1, 15'h82));
      applyStimulus(mkVec(5, 1, 1, 0, 0, 1, 1, 15'h81, 1, 1, 15'h83));
      cmp("addr_err sticky", 5, 32'(addr_err), 32'd1);

      // Reset with three words queued and one in flight
      applyStimulus(mkVec(6, 1, 0, 1, 15'h200, 0, 0, 0, 1, 0, 0));
      applyStimulus(mkVec(6, 1, 0, 0, 0, 1, 0, 0, 1, 1, 15'h200));
      applyStimulus(mkVec(6, 1, 0, 0, 0, 1, 0, 0, 1, 1, 15'h201));
      applyStimulus(mkVec(6, 1, 0, 0, 0, 1, 1, 15'h200, 1, 1, 15'h202));
      applyStimulus(mkVec(6, 1, 0, 0, 0, 1, 1, 15'h200, 1, 1, 15'h203));
      applyStimulus(mkVec(6, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0));
      cmp("mid-rst instr_addr", 6, 32'(instr_addr), 32'd0);
      cmp("mid-rst instr_data", 6, instr_data, 32'd0);
      applyStimulus(mkVec(6, 1, 1, 0, 0, 1, 0, 0, 1, 1, 0));
      cmp("addr_err after rst", 6, 32'(addr_err), 32'd0);
      applyStimulus(mkVec(6, 1, 1, 0, 0, 1, 0, 0, 1, 1, 1));
      applyStimulus(mkVec(6, 1, 1, 0, 0, 1, 1, 0, 1, 1, 2));
      applyStimulus(mkVec(6, 1, 1, 0, 0, 1, 1, 1, 1, 1, 3));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
      $finish;
   end

endmodule
